nn_train_sequencer: RTL
=======================

// Module: nn_train_sequencer
// PURPOSE
//  Upstream control stage for the 3-ReLU/1-sigmoid XOR network datapath. Steps the datapath
//  through load -> forward -> backward -> write-back for each training sample, supplies
//  x/y inputs from a built-in 4-entry XOR dataset, and drives all RAM/register enables.
//  After NUM_EPOCHS it runs one test pass and scores predicted against expected.
//  Replaces the free-running counter and clk2 with a single-clock, strobe-driven schedule.
// PARAMETERS
//  NUM_EPOCHS     1000  training passes over the 4 samples; 0 = go straight to test pass
//  EPOCH_W        16    width of epoch counter (must hold NUM_EPOCHS)
//  SETTLE_CYCLES  4     wait cycles for combinational FP/BP logic to settle, >=1
// PORTS
//  clk          in   1        single clock, rising edge
//  reset        in   1        asynchronous, active-high reset
//  start        in   1        1-cycle pulse; sampled only in IDLE or DONE
//  predicted    in   2        datapath prediction: 2'b10=1, 2'b01=0, 2'b00=invalid
//  expected     in   2        datapath expected label, same encoding
//  x_input      out  1        sample x bit
//  y_input      out  1        sample y bit
//  read_en      out  1        weight RAM read strobe
//  write_en     out  1        weight RAM write-back strobe
//  read_en1     out  1        FP capture RAM read strobe
//  write_en1    out  1        FP capture RAM write strobe
//  read_en2     out  1        BP result RAM read strobe
//  write_en2    out  1        BP result RAM write strobe
//  reg_load     out  1        1-cycle load strobe for weight/input registers (replaces clk2)
//  TestFlag     out  1        1 during the test pass
//  busy         out  1        1 in any state other than IDLE/DONE
//  done         out  1        1 in DONE, held until start or reset
//  epoch        out  EPOCH_W  completed training epochs
//  correct      out  3        correct test predictions, 0..4
// BEHAVIOUR
//  Reset: state=IDLE; all strobes, TestFlag, busy, done=0; x/y=0; epoch=0; correct=0.
//  Sample index idx[1:0] runs 0..3; x_input=idx[1], y_input=idx[0]; outputs are registered.
//  States, training (one cycle each unless stated):
//   LOAD (read_en) -> LATCH (reg_load) -> FP_SET (SETTLE_CYCLES) -> FP_WR (write_en1)
//   -> FP_RD (read_en1) -> BP_SET (SETTLE_CYCLES) -> BP_WR (write_en2) -> BP_RD (read_en2)
//   -> WB (write_en) -> NEXT.
//  Training sample latency = 7 + 2*SETTLE_CYCLES cycles (15 at default).
//  NEXT: idx wraps 3->0 and increments epoch; if epoch==NUM_EPOCHS, enter test with idx=0.
//  Test path: T_LOAD (read_en) -> T_LATCH (reg_load) -> T_SET (SETTLE_CYCLES) -> T_EVAL -> T_NEXT.
//   TestFlag=1 in all test states. T_EVAL: correct++ iff predicted==expected and predicted!=0.
//   After idx 3 -> DONE.
//  Strobes are 1-cycle pulses. At most one RAM strobe is high per cycle; a read_en/write_en
//   pair is never high together.
//  start in IDLE/DONE: clear epoch, correct, idx, done; go to LOAD, or T_LOAD if NUM_EPOCHS=0.
//   start while busy is ignored.
//  Reset mid-operation: immediate async return to the reset values. Weight RAMs keep their
//   contents; the datapath reset reloads the initial weights.
//  Settle counter is loaded with SETTLE_CYCLES-1 on entry and the state exits when it reaches 0.
//  No epoch saturation is needed because the terminal compare stops counting.
// STRUCTURE
//  Package nn_seq_pkg: state_t enum, PRED_ONE=2'b10 / PRED_ZERO=2'b01 / PRED_NONE=2'b00,
//   XOR_DATASET[4] constant ({x,y,label}).
//  Sub-module xor_dataset_rom: idx -> {x,y,label}. Keeping it separate lets a larger training
//   ROM replace it without changing the FSM.
//  Top level: one FSM, settle counter, idx/epoch/correct counters.
// TESTING
//  1 NUM_EPOCHS=1, SETTLE=4, start -> strobe order LOAD..WB per sample, 15 cycles each;
//    epoch=1 at cycle 60; then 4 test samples of 7 cycles; done at end.
//  2 Every cycle -> at most one strobe high; read_en&write_en, read_en1&write_en1,
//    read_en2&write_en2 never high together.
//  3 Test pass with predicted==expected forced (2'b10/2'b01) -> correct=4;
//    with predicted=2'b00 -> correct=0.
//  4 Assert reset during BP_SET of epoch 0 sample 2 -> all outputs 0 in the same cycle, IDLE;
//    a new start restarts at idx=0, epoch=0.
//  5 NUM_EPOCHS=0, start -> first strobe is read_en with TestFlag=1; no write_en1/2 ever asserted.
//  6 Pulse start while busy -> ignored, schedule unchanged.
//    Pulse start in DONE -> done=0, correct=0, new run begins.

Source files
------------

// File: rtl/nn_seq_pkg.sv
// nn_seq_pkg: sequencer states, prediction encodings and the built-in XOR training set
package nn_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        LATCH,
        FP_SET,
        FP_WR,
        FP_RD,
        BP_SET,
        BP_WR,
        BP_RD,
        WB,
        T_LOAD,
        T_LATCH,
        T_SET,
        T_EVAL,
        DONE
    } state_t;

    typedef struct packed {
        logic x;
        logic y;
        logic label;
    } sample_t;

    localparam logic [1:0] PRED_ONE  = 2'b10;
    localparam logic [1:0] PRED_ZERO = 2'b01;
    localparam logic [1:0] PRED_NONE = 2'b00;

    localparam sample_t XOR_DATASET [4] = '{3'b000, 3'b011, 3'b101, 3'b110};

    function automatic logic pred_hit(input logic [1:0] p, input logic [1:0] e);
        return p == e && p != PRED_NONE;
    endfunction

endpackage

// File: rtl/xor_dataset_rom.sv
// xor_dataset_rom: maps a sample index to its {x, y, label} training record
module xor_dataset_rom
    import nn_seq_pkg::*;
(
    input  logic [1:0] idx,
    output sample_t    sample
);

    assign sample = XOR_DATASET[idx];

endmodule

// File: rtl/nn_train_sequencer.sv
// nn_train_sequencer: single-clock strobe schedule driving the XOR network through training and a scored test pass
module nn_train_sequencer
    import nn_seq_pkg::*;
#(
    parameter int NUM_EPOCHS    = 1000,
    parameter int EPOCH_W       = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         predicted,
    input  logic [1:0]         expected,
    output logic               x_input,
    output logic               y_input,
    output logic               read_en,
    output logic               write_en,
    output logic               read_en1,
    output logic               write_en1,
    output logic               read_en2,
    output logic               write_en2,
    output logic               reg_load,
    output logic               TestFlag,
    output logic               busy,
    output logic               done,
    output logic [EPOCH_W-1:0] epoch,
    output logic [2:0]         correct
);

    localparam int                 SW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0]      SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [EPOCH_W-1:0] EPOCH_LAST  = EPOCH_W'(NUM_EPOCHS);

    state_t             state, state_n;
    logic [1:0]         idx, idx_n;
    logic [SW-1:0]      settle, settle_n;
    logic [EPOCH_W-1:0] epoch_n;
    logic [2:0]         correct_n;
    sample_t            sample_n;
    logic               unused_label;

    xor_dataset_rom u_rom (
        .idx    (idx_n),
        .sample (sample_n)
    );

    assign unused_label = sample_n.label;

    // Next-state, sample index, settle countdown and epoch/score bookkeeping
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        settle_n  = settle;
        epoch_n   = epoch;
        correct_n = correct;
        case (state)
            IDLE, DONE: if (start) begin
                idx_n     = '0;
                epoch_n   = '0;
                correct_n = '0;
                state_n   = NUM_EPOCHS == 0 ? T_LOAD : LOAD;
            end
            LOAD:    state_n = LATCH;
            LATCH: begin
                settle_n = SETTLE_LOAD;
                state_n  = FP_SET;
            end
            FP_SET: begin
                settle_n = settle - 1'b1;
                state_n  = settle == '0 ? FP_WR : FP_SET;
            end
            FP_WR:   state_n = FP_RD;
            FP_RD: begin
                settle_n = SETTLE_LOAD;
                state_n  = BP_SET;
            end
            BP_SET: begin
                settle_n = settle - 1'b1;
                state_n  = settle == '0 ? BP_WR : BP_SET;
            end
            BP_WR:   state_n = BP_RD;
            BP_RD:   state_n = WB;
            WB: begin
                idx_n   = idx + 2'd1;
                epoch_n = idx == 2'd3 ? epoch + 1'b1 : epoch;
                state_n = idx == 2'd3 && epoch_n == EPOCH_LAST ? T_LOAD : LOAD;
            end
            T_LOAD:  state_n = T_LATCH;
            T_LATCH: begin
                settle_n = SETTLE_LOAD;
                state_n  = T_SET;
            end
            T_SET: begin
                settle_n = settle - 1'b1;
                state_n  = settle == '0 ? T_EVAL : T_SET;
            end
            T_EVAL: begin
                correct_n = pred_hit(predicted, expected) ? correct + 3'd1 : correct;
                idx_n     = idx + 2'd1;
                state_n   = idx == 2'd3 ? DONE : T_LOAD;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters and registered strobes decoded from the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            settle    <= '0;
            epoch     <= '0;
            correct   <= '0;
            x_input   <= 1'b0;
            y_input   <= 1'b0;
            read_en   <= 1'b0;
            write_en  <= 1'b0;
            read_en1  <= 1'b0;
            write_en1 <= 1'b0;
            read_en2  <= 1'b0;
            write_en2 <= 1'b0;
            reg_load  <= 1'b0;
            TestFlag  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            settle    <= settle_n;
            epoch     <= epoch_n;
            correct   <= correct_n;
            x_input   <= sample_n.x;
            y_input   <= sample_n.y;
            read_en   <= state_n == LOAD || state_n == T_LOAD;
            write_en  <= state_n == WB;
            read_en1  <= state_n == FP_RD;
            write_en1 <= state_n == FP_WR;
            read_en2  <= state_n == BP_RD;
            write_en2 <= state_n == BP_WR;
            reg_load  <= state_n == LATCH || state_n == T_LATCH;
            TestFlag  <= state_n inside {T_LOAD, T_LATCH, T_SET, T_EVAL};
            busy      <= !(state_n inside {IDLE, DONE});
            done      <= state_n == DONE;
        end
    end

endmodule
